irq_sched: RTL and testbench

Machine-level interrupt scheduler for the pipelined RV32 core. It owns the machine timer (prescaled `mtime` and `mtimecmp`), captures the UART external interrupt and a software interrupt, and arbitrates among them by fixed priority. It presents one request at a time to the datapath's trap logic over a request/acknowledge/done handshake. It replaces the ad-hoc OR of the timer and external interrupt vectors at the top level.

---
 rtl/irq_sched.sv | 151 +++++++++++++++
 tb/tb_irq_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_sched.sv
// rtl/irq_sched.sv - machine timer, interrupt capture and fixed-priority request/ack/done scheduler
module irq_sched #(
  parameter int WIDTH = 32,
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_wdata,
  input  logic             ext_irq,
  input  logic             irq_ack,
  input  logic             irq_done,
  output logic             irq_req,
  output logic [WIDTH-1:0] irq_cause,
  output logic [WIDTH-1:0] mtime
);

  localparam logic [WIDTH-1:0] CAUSE_EXT = WIDTH'(12'h800);
  localparam logic [WIDTH-1:0] CAUSE_TMR = WIDTH'(12'h080);
  localparam logic [WIDTH-1:0] CAUSE_SW  = WIDTH'(12'h008);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [WIDTH-1:0]  cause_q, cause_d;
  logic [WIDTH-1:0]  mtime_q, mtime_d;
  logic [WIDTH-1:0]  mtimecmp_q, mtimecmp_d;
  logic [PRE_W-1:0]  reload_q, reload_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [2:0]        en_q, en_d;     // {ext, tmr, sw} = mask bits {11, 7, 3}
  logic              meip_q, meip_d;
  logic              msip_q, msip_d;
  logic              ext_prev_q;

  logic wr_cmp, wr_pre, wr_en, wr_sw;
  logic mtip, el_ext, el_sw, el_tmr;
  logic ack_take, clr_ext, clr_sw;
  logic unused_wdata;

  assign wr_cmp = cfg_we && (cfg_addr == 2'd0);
  assign wr_pre = cfg_we && (cfg_addr == 2'd1);
  assign wr_en  = cfg_we && (cfg_addr == 2'd2);
  assign wr_sw  = cfg_we && (cfg_addr == 2'd3);
  assign unused_wdata = ^cfg_wdata;

  assign mtip   = (mtime_q >= mtimecmp_q);
  assign el_ext = meip_q & en_q[2];
  assign el_tmr = mtip   & en_q[1];
  assign el_sw  = msip_q & en_q[0];

  assign ack_take = (state_q == REQ) && irq_ack;
  assign clr_ext  = ack_take && (cause_q == CAUSE_EXT);
  assign clr_sw   = ack_take && (cause_q == CAUSE_SW);

  always_comb begin
    mtime_d    = mtime_q;
    pre_d      = pre_q;
    reload_d   = reload_q;
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    msip_d     = msip_q;
    meip_d     = meip_q;

    if (pre_q == '0) begin
      pre_d   = reload_q;
      mtime_d = mtime_q + WIDTH'(1);
    end else begin
      pre_d = pre_q - PRE_W'(1);
    end
    if (wr_pre) begin
      reload_d = cfg_wdata[PRE_W-1:0];
      pre_d    = cfg_wdata[PRE_W-1:0];
    end
    if (wr_cmp) mtimecmp_d = cfg_wdata;
    if (wr_en)  en_d = {cfg_wdata[11], cfg_wdata[7], cfg_wdata[3]};

    // Config write beats the ack clear; a fresh edge beats the ack clear.
    if (wr_sw)       msip_d = cfg_wdata[3];
    else if (clr_sw) msip_d = 1'b0;
    meip_d = (ext_irq & ~ext_prev_q) | (meip_q & ~clr_ext);
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cause_d = cause_q;
    unique case (state_q)
      IDLE: begin
        if (el_ext | el_sw | el_tmr) begin
          req_d   = 1'b1;
          state_d = REQ;
          if (el_ext)     cause_d = CAUSE_EXT;
          else if (el_sw) cause_d = CAUSE_SW;
          else            cause_d = CAUSE_TMR;
        end
      end
      REQ: begin
        if (irq_ack) begin
          req_d   = 1'b0;
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (irq_done) begin
          cause_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        cause_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      cause_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      reload_q   <= '0;
      pre_q      <= '0;
      en_q       <= '0;
      meip_q     <= 1'b0;
      msip_q     <= 1'b0;
      ext_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      cause_q    <= cause_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      reload_q   <= reload_d;
      pre_q      <= pre_d;
      en_q       <= en_d;
      meip_q     <= meip_d;
      msip_q     <= msip_d;
      ext_prev_q <= ext_irq;
    end
  end

  assign irq_req   = req_q;
  assign irq_cause = cause_q;
  assign mtime     = mtime_q;

endmodule

// File: tb/tb_irq_sched.sv
// tb/tb_irq_sched.sv - directed self-checking bench for irq_sched
module tb_irq_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_wdata = 32'd0;
  logic        ext_irq = 1'b0;
  logic        irq_ack = 1'b0;
  logic        irq_done = 1'b0;
  logic        irq_req;
  logic [31:0] irq_cause;
  logic [31:0] mtime;

  // Narrow instance so the 2^WIDTH wrap is reachable in a short run.
  logic        reset2 = 1'b0;
  logic        cfg_we2 = 1'b0;
  logic [1:0]  cfg_addr2 = 2'd0;
  logic [11:0] cfg_wdata2 = 12'd0;
  logic        zero2 = 1'b0;
  logic        irq_req2;
  logic [11:0] irq_cause2;
  logic [11:0] mtime2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  irq_sched #(.WIDTH(32), .PRE_W(16)) u_dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .ext_irq(ext_irq), .irq_ack(irq_ack), .irq_done(irq_done),
    .irq_req(irq_req), .irq_cause(irq_cause), .mtime(mtime)
  );

  irq_sched #(.WIDTH(12), .PRE_W(4)) u_dut_w12 (
    .clk(clk), .reset(reset2), .cfg_we(cfg_we2), .cfg_addr(cfg_addr2), .cfg_wdata(cfg_wdata2),
    .ext_irq(zero2), .irq_ack(zero2), .irq_done(zero2),
    .irq_req(irq_req2), .irq_cause(irq_cause2), .mtime(mtime2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_wr(input logic [1:0] addr, input logic [31:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
  endtask

  task automatic pulse_done();
    irq_done = 1'b1;
    @(negedge clk);
    irq_done = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!irq_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!irq_req) check(tag, 32'(irq_req), 32'd1);
  endtask

  logic [31:0] prio_exp [3];

  initial begin
    prio_exp[0] = 32'h800; prio_exp[1] = 32'h008; prio_exp[2] = 32'h080;

    // Reset state
    tick(2);
    check("rst_req", 32'(irq_req), 32'd0);
    check("rst_cause", irq_cause, 32'd0);
    check("rst_mtime", mtime, 32'd0);
    reset = 1'b1;

    // Timer: mtime=k after edge k; cmp=40 -> request seen when mtime=41
    cfg_wr(2'd2, 32'h080);
    cfg_wr(2'd0, 32'd40);
    wait_req("tmr_timeout");
    check("tmr_mtime_at_req", mtime, 32'd41);
    check("tmr_cause", irq_cause, 32'h080);
    pulse_ack();
    check("tmr_ack_req", 32'(irq_req), 32'd0);
    check("tmr_svc_cause", irq_cause, 32'h080);
    cfg_wr(2'd0, 32'hFFFF_FFFF);
    pulse_done();
    check("tmr_done_cause", irq_cause, 32'd0);
    tick(3);
    check("tmr_no_rereq", 32'(irq_req), 32'd0);

    // Priority: all three eligible at once after the enable write
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    cfg_wr(2'd3, 32'h8);
    cfg_wr(2'd0, 32'd0);
    ext_irq = 1'b1;
    tick(1);
    ext_irq = 1'b0;
    tick(1);
    check("prio_masked", 32'(irq_req), 32'd0);
    cfg_wr(2'd2, 32'h888);
    tick(1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("prio_req%0d", i), 32'(irq_req), 32'd1);
      check($sformatf("prio_cause%0d", i), irq_cause, prio_exp[i]);
      pulse_ack();
      check($sformatf("prio_ack%0d", i), 32'(irq_req), 32'd0);
      if (i == 2) cfg_wr(2'd0, 32'hFFFF_FFFF);
      pulse_done();
      check($sformatf("prio_gap%0d", i), 32'(irq_req), 32'd0);
      check($sformatf("prio_idle_cause%0d", i), irq_cause, 32'd0);
      tick(1);
    end
    check("prio_drained", 32'(irq_req), 32'd0);

    // Spurious ack in IDLE must not clear msip; spurious done in REQ ignored
    cfg_wr(2'd2, 32'h0);
    cfg_wr(2'd3, 32'h8);
    pulse_ack();
    tick(1);
    check("spur_masked", 32'(irq_req), 32'd0);
    cfg_wr(2'd2, 32'h008);
    tick(1);
    check("spur_req", 32'(irq_req), 32'd1);
    check("spur_cause", irq_cause, 32'h008);
    pulse_done();
    check("done_in_req", 32'(irq_req), 32'd1);

    // Hold stability with pending and enable removed
    cfg_wr(2'd3, 32'h0);
    cfg_wr(2'd2, 32'h0);
    tick(1);
    check("hold_req", 32'(irq_req), 32'd1);
    check("hold_cause", irq_cause, 32'h008);
    irq_ack = 1'b1; irq_done = 1'b1;
    tick(1);
    irq_ack = 1'b0; irq_done = 1'b0;
    check("ackdone_req", 32'(irq_req), 32'd0);
    check("ackdone_cause", irq_cause, 32'h008);
    tick(2);
    check("svc_hold_cause", irq_cause, 32'h008);
    pulse_done();
    check("svc_done_cause", irq_cause, 32'd0);
    tick(2);
    check("svc_no_rereq", 32'(irq_req), 32'd0);

    // External edge timing and new edge in the ack cycle
    cfg_wr(2'd2, 32'h800);
    ext_irq = 1'b1;
    tick(1);
    check("ext_k", 32'(irq_req), 32'd0);
    tick(1);
    check("ext_k1_req", 32'(irq_req), 32'd1);
    check("ext_k1_cause", irq_cause, 32'h800);
    ext_irq = 1'b0;
    tick(1);
    ext_irq = 1'b1; irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0; ext_irq = 1'b0;
    check("ext_ack_req", 32'(irq_req), 32'd0);
    pulse_done();
    check("ext_done_gap", 32'(irq_req), 32'd0);
    tick(1);
    check("ext_rereq", 32'(irq_req), 32'd1);
    check("ext_rereq_cause", irq_cause, 32'h800);

    // Asynchronous reset mid-SERVICE
    pulse_ack();
    check("pre_rst_cause", irq_cause, 32'h800);
    #2 reset = 1'b0;
    #1;
    check("arst_req", 32'(irq_req), 32'd0);
    check("arst_cause", irq_cause, 32'd0);
    check("arst_mtime", mtime, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    ext_irq = 1'b1;
    tick(10);
    ext_irq = 1'b0;
    check("arst_en_cleared", 32'(irq_req), 32'd0);

    // Prescale and wrap on the 12-bit instance
    reset2 = 1'b1;
    begin
      int n = 0;
      while (mtime2 != 12'hFFC && n < 5000) begin
        @(negedge clk);
        n++;
      end
      check("w12_reach", 32'(mtime2), 32'hFFC);
    end
    cfg_we2 = 1'b1; cfg_addr2 = 2'd1; cfg_wdata2 = 12'd3;
    @(negedge clk);
    cfg_we2 = 1'b0;
    check("w12_start", 32'(mtime2), 32'hFFD);
    for (int i = 1; i <= 12; i++) begin
      logic [11:0] e;
      e = 12'hFFD + 12'(i / 4);
      @(negedge clk);
      check($sformatf("w12_c%0d", i), 32'(mtime2), 32'(e));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
